// File: rtl/cfu_pipelined_if.sv
// CFU request/response port between the core (master) and a function unit (slave).
//
// Handshake rules for both channels:
// - A transfer happens on a rising edge where valid & ready are both high.
// - Once valid is raised, the sender holds valid and its payload stable
//   until the transfer.
// - ready may change freely and never depends combinationally on valid.
interface cfu_pipelined_if #(
    parameter int ID_W = 4
);
    logic            req_valid;
    logic            req_ready;
    logic [ID_W-1:0] req_id;
    logic [7:0]      req_cfu;
    logic [2:0]      req_func;
    logic [31:0]     req_data0;
    logic [31:0]     req_data1;

    logic            resp_valid;
    logic            resp_ready;
    logic [ID_W-1:0] resp_id;
    logic            resp_status;
    logic [31:0]     resp_data;

    modport master (
        output req_valid, req_id, req_cfu, req_func, req_data0, req_data1, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_status, resp_data
    );

    modport slave (
        input  req_valid, req_id, req_cfu, req_func, req_data0, req_data1, resp_ready,
        output req_ready, resp_valid, resp_id, resp_status, resp_data
    );
endinterface

// File: rtl/cfu_pipelined.sv
// Pipelined multi-outstanding CFU: SHA-256 sigma/sum and CRC-32 byte update.
// Results travel through LATENCY-1 register stages into a response FIFO.
// A credit counter covering in-flight and queued entries gates req_ready,
// so the pipeline never has to stall and the FIFO can never overflow.
module cfu_pipelined #(
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int ID_W       = 4
) (
    input logic          clk,
    input logic          rst,
    cfu_pipelined_if.slave cfu
);
    localparam int          CW   = $clog2(FIFO_DEPTH + 1);
    localparam int          PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int          EW   = ID_W + 33;
    localparam logic [31:0] POLY = 32'hEDB88320;

    // ------------------------------------------------------------------
    // Function decode
    // ------------------------------------------------------------------
    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            c = (c >> 1) ^ (c[0] ? POLY : 32'h0);
        end
        return c;
    endfunction

    logic [31:0] x;
    logic [31:0] op_data;
    logic        op_status;
    logic        unused_data1;

    assign x            = cfu.req_data0;
    assign unused_data1 = ^cfu.req_data1[31:8];

    // Combinational compute of the accepted request's result and status
    always_comb begin
        op_data   = 32'h0;
        op_status = 1'b0;
        if (cfu.req_cfu == 8'd1) begin
            case (cfu.req_func)
                3'd0:    op_data = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
                3'd1:    op_data = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'h000, x[31:10]};
                3'd2:    op_data = {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
                3'd3:    op_data = {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
                default: op_status = 1'b1;
            endcase
        end else if (cfu.req_cfu == 8'd0 && cfu.req_func == 3'd0) begin
            op_data = crc_byte(cfu.req_data0, cfu.req_data1[7:0]);
        end else begin
            op_status = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Credit counter and acceptance
    // ------------------------------------------------------------------
    logic [CW-1:0] credit;
    logic          ready;
    logic          accept;
    logic          pop;
    logic          not_empty;

    assign ready         = (credit < CW'(FIFO_DEPTH));
    assign cfu.req_ready = ready;
    assign accept        = cfu.req_valid & ready;
    assign pop           = not_empty & cfu.resp_ready;

    // Credit: one per accepted request, returned when its response is popped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credit <= '0;
        end else if (accept && !pop) begin
            credit <= credit + CW'(1);
        end else if (!accept && pop) begin
            credit <= credit - CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Fixed-latency pipeline feeding the FIFO write port
    // ------------------------------------------------------------------
    logic            wr_v;
    logic [ID_W-1:0] wr_id;
    logic            wr_st;
    logic [31:0]     wr_data;

    if (LATENCY == 1) begin : g_direct
        assign wr_v    = accept;
        assign wr_id   = cfu.req_id;
        assign wr_st   = op_status;
        assign wr_data = op_data;
    end else begin : g_stages
        localparam int NS = LATENCY - 1;
        logic [NS-1:0]   st_v;
        logic [ID_W-1:0] st_id   [NS];
        logic            st_s    [NS];
        logic [31:0]     st_data [NS];

        // Stage valid bits shift every cycle; reset discards in-flight work
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                st_v <= '0;
            end else begin
                st_v[0] <= accept;
                for (int k = 1; k < NS; k++) begin
                    st_v[k] <= st_v[k-1];
                end
            end
        end

        // Payload follows its valid bit; it is only consumed when tagged valid
        always_ff @(posedge clk) begin
            st_id[0]   <= cfu.req_id;
            st_s[0]    <= op_status;
            st_data[0] <= op_data;
            for (int k = 1; k < NS; k++) begin
                st_id[k]   <= st_id[k-1];
                st_s[k]    <= st_s[k-1];
                st_data[k] <= st_data[k-1];
            end
        end

        assign wr_v    = st_v[NS-1];
        assign wr_id   = st_id[NS-1];
        assign wr_st   = st_s[NS-1];
        assign wr_data = st_data[NS-1];
    end

    // ------------------------------------------------------------------
    // Response FIFO (circular, any depth)
    // ------------------------------------------------------------------
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] fill;
    logic [EW-1:0] head;

    // Entry storage: written from the last pipeline stage
    always_ff @(posedge clk) begin
        if (wr_v) begin
            mem[wr_ptr] <= {wr_id, wr_st, wr_data};
        end
    end

    // Pointers and occupancy; write and pop may coincide in any state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (wr_v) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (wr_v && !pop) begin
                fill <= fill + CW'(1);
            end else if (!wr_v && pop) begin
                fill <= fill - CW'(1);
            end
        end
    end

    assign not_empty       = (fill != '0);
    assign head            = mem[rd_ptr];
    assign cfu.resp_valid  = not_empty;
    assign cfu.resp_id     = not_empty ? head[EW-1:33] : '0;
    assign cfu.resp_status = not_empty ? head[32] : 1'b0;
    assign cfu.resp_data   = not_empty ? head[31:0] : 32'h0;
endmodule

// File: tb/tb_cfu_pipelined.sv
// Bench for cfu_pipelined: a depth-4 instance exercised by directed and
// random phases, plus a depth-3 instance under continuous random traffic.
// Expected responses are queued on acceptance and checked by monitors.
module tb_cfu_pipelined;
    localparam int ID_W   = 4;
    localparam int LAT    = 2;
    localparam int DEPTH  = 4;
    localparam int DEPTH3 = 3;
    localparam int EW     = ID_W + 33;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;
    logic rst3_n;

    cfu_pipelined_if #(.ID_W(ID_W)) cf ();
    cfu_pipelined_if #(.ID_W(ID_W)) cf3 ();

    cfu_pipelined #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst_n), .cfu(cf)
    );
    cfu_pipelined #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH3), .ID_W(ID_W)) dut3 (
        .clk(clk), .rst(rst3_n), .cfu(cf3)
    );

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int pops  = 0;
    bit done3 = 1'b0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] exp3_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event did not match expectation", name);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ror(input logic [31:0] v, input int n);
        return (v >> n) | (v << (32 - n));
    endfunction

    function automatic logic [32:0] model(input logic [7:0] c, input logic [2:0] f,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        if (c == 8'd1 && f == 3'd0) return {1'b0, ror(a, 7) ^ ror(a, 18) ^ (a >> 3)};
        if (c == 8'd1 && f == 3'd1) return {1'b0, ror(a, 17) ^ ror(a, 19) ^ (a >> 10)};
        if (c == 8'd1 && f == 3'd2) return {1'b0, ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)};
        if (c == 8'd1 && f == 3'd3) return {1'b0, ror(a, 6) ^ ror(a, 11) ^ ror(a, 25)};
        if (c == 8'd0 && f == 3'd0) begin
            r = a ^ {24'h0, b[7:0]};
            for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
            return {1'b0, r};
        end
        return {1'b1, 32'h0};
    endfunction

    task automatic rand_req(output logic [7:0] c, output logic [2:0] f,
                            output logic [31:0] a, output logic [31:0] b);
        int sel;
        sel = $urandom_range(0, 9);
        a   = $urandom;
        b   = $urandom;
        if (sel < 4) begin
            c = 8'd1; f = 3'(sel);
        end else if (sel < 6) begin
            c = 8'd0; f = 3'd0;
        end else if (sel == 6) begin
            c = 8'd1; f = 3'($urandom_range(4, 7));
        end else if (sel == 7) begin
            c = 8'd0; f = 3'($urandom_range(1, 7));
        end else begin
            c = 8'($urandom_range(2, 255)); f = 3'($urandom_range(0, 7));
        end
    endtask

    // ---------------- driver tasks (depth-4 DUT) ----------------
    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [ID_W-1:0] id, input logic [7:0] c, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] b, input logic [32:0] e,
                        output int waits);
        bit acc;
        waits        = 0;
        cf.req_valid = 1'b1;
        cf.req_id    = id;
        cf.req_cfu   = c;
        cf.req_func  = f;
        cf.req_data0 = a;
        cf.req_data1 = b;
        @(negedge clk);
        while (!cf.req_ready && waits < 300) begin
            waits++;
            @(negedge clk);
        end
        acc = cf.req_ready;
        if (!acc) fail("req_accept_timeout");
        @(posedge clk);
        #1;
        if (acc) exp_q.push_back({id, e});
        cf.req_valid = 1'b0;
    endtask

    task automatic send_rand(input logic [ID_W-1:0] id, output int waits);
        logic [7:0] c; logic [2:0] f; logic [31:0] a, b;
        rand_req(c, f, a, b);
        send(id, c, f, a, b, model(c, f, a, b), waits);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (exp_q.size() != 0) fail("drain_timeout");
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"},   cf.req_ready,   1);
        check({tag, "_resp_valid"},  cf.resp_valid,  0);
        check({tag, "_resp_id"},     cf.resp_id,     0);
        check({tag, "_resp_status"}, cf.resp_status, 0);
        check({tag, "_resp_data"},   cf.resp_data,   0);
    endtask

    // ---------------- monitor (depth-4 DUT) ----------------
    // Checks credit-based ready, response holding and in-order data.
    logic          hold_v = 1'b0;
    logic [EW-1:0] hold_e;
    always @(negedge clk) begin
        logic [EW-1:0] got;
        logic [EW-1:0] e;
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            check("req_ready_credit", cf.req_ready, (exp_q.size() < DEPTH));
            got = {cf.resp_id, cf.resp_status, cf.resp_data};
            if (hold_v) begin
                check("resp_hold_valid", cf.resp_valid, 1);
                check("resp_hold_data", got, hold_e);
            end
            hold_v = 1'b0;
            if (cf.resp_valid && !cf.resp_ready) begin
                hold_v = 1'b1;
                hold_e = got;
            end
            if (cf.resp_valid && cf.resp_ready) begin
                if (exp_q.size() == 0) begin
                    fail("resp_unexpected");
                end else begin
                    e = exp_q.pop_front();
                    check("resp_payload", got, e);
                    pops++;
                end
            end
        end
    end

    // ---------------- depth-3 DUT: random traffic + monitor ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (rst3_n) begin
            check("d3_req_ready_credit", cf3.req_ready, (exp3_q.size() < DEPTH3));
            if (cf3.resp_valid && cf3.resp_ready) begin
                if (exp3_q.size() == 0) begin
                    fail("d3_resp_unexpected");
                end else begin
                    e = exp3_q.pop_front();
                    check("d3_resp_payload", {cf3.resp_id, cf3.resp_status, cf3.resp_data}, e);
                end
            end
        end
    end

    initial begin
        cf3.resp_ready = 1'b0;
        while (!done3) begin
            @(posedge clk);
            #1;
            cf3.resp_ready = ($urandom_range(0, 2) == 0);
        end
        cf3.resp_ready = 1'b1;
    end

    initial begin
        logic [7:0] c; logic [2:0] f; logic [31:0] a, b;
        int w;
        bit acc;
        cf3.req_valid = 1'b0;
        cf3.req_id    = '0;
        cf3.req_cfu   = '0;
        cf3.req_func  = '0;
        cf3.req_data0 = '0;
        cf3.req_data1 = '0;
        rst3_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst3_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk);
                #1;
            end
            rand_req(c, f, a, b);
            cf3.req_valid = 1'b1;
            cf3.req_id    = ID_W'(i);
            cf3.req_cfu   = c;
            cf3.req_func  = f;
            cf3.req_data0 = a;
            cf3.req_data1 = b;
            w = 0;
            @(negedge clk);
            while (!cf3.req_ready && w < 300) begin
                w++;
                @(negedge clk);
            end
            acc = cf3.req_ready;
            if (!acc) fail("d3_accept_timeout");
            @(posedge clk);
            #1;
            if (acc) exp3_q.push_back({ID_W'(i), model(c, f, a, b)});
            cf3.req_valid = 1'b0;
        end
        w = 0;
        while (exp3_q.size() != 0 && w < 400) begin
            @(posedge clk);
            w++;
        end
        if (exp3_q.size() != 0) fail("d3_drain_timeout");
        done3 = 1'b1;
    end

    // ---------------- main directed/random sequence ----------------
    initial begin
        int  w;
        int  p0;
        bit  sends_done;
        cf.req_valid  = 1'b0;
        cf.req_id     = '0;
        cf.req_cfu    = '0;
        cf.req_func   = '0;
        cf.req_data0  = '0;
        cf.req_data1  = '0;
        cf.resp_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;

        // Single op: valid appears exactly LATENCY edges after acceptance
        send(4'd3, 8'd1, 3'd0, 32'h1, 32'h0, {1'b0, 32'h02004000}, w);
        check("single_first_edge_accept", w, 0);
        check("single_valid_e1", cf.resp_valid, 0);
        @(posedge clk);
        #1;
        check("single_valid_e2", cf.resp_valid, 1);
        check("single_data", cf.resp_data, 32'h02004000);
        check("single_id", cf.resp_id, 3);
        check("single_status", cf.resp_status, 0);
        cf.resp_ready = 1'b1;
        wait_drain();

        // Known answers: sum0, CRC byte, illegal pair
        send(4'd1, 8'd1, 3'd2, 32'h1, 32'h0, {1'b0, 32'h40080400}, w);
        send(4'd2, 8'd0, 3'd0, 32'hFFFFFFFF, 32'h0, {1'b0, 32'h2DFD1072}, w);
        send(4'd5, 8'd5, 3'd0, 32'h12345678, 32'h9, {1'b1, 32'h0}, w);
        send(4'd6, 8'd1, 3'd1, 32'h1, 32'h0, {1'b0, 32'h0000A000}, w);
        wait_drain();

        // Backpressure: four fill the FIFO, the next two wait for credits
        cf.resp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_rand(ID_W'(i), w);
            check("bp_fill_no_wait", w, 0);
        end
        @(negedge clk);
        check("bp_ready_low_after_4", cf.req_ready, 0);
        fork
            begin
                send_rand(4'd4, w);
                send_rand(4'd5, w);
            end
            begin
                repeat (4) begin
                    @(negedge clk);
                    check("bp_ready_stays_low", cf.req_ready, 0);
                end
                @(posedge clk);
                #1;
                cf.resp_ready = 1'b1;
            end
        join
        wait_drain();

        // Streaming: 32 back-to-back, one response per cycle
        p0 = pops;
        for (int i = 0; i < 32; i++) begin
            send_rand(ID_W'(i), w);
            check("stream_no_wait", w, 0);
        end
        repeat (3) @(posedge clk);
        #1;
        check("stream_resp_count", pops - p0, 32);
        check("stream_queue_empty", exp_q.size(), 0);

        // Full FIFO with random pops: accepts and pops coincide across wrap
        cf.resp_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_rand(ID_W'(i), w);
        sends_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) send_rand(ID_W'(i), w);
                sends_done = 1'b1;
            end
            begin
                int n = 0;
                while (!sends_done && n < 2000) begin
                    @(posedge clk);
                    #1;
                    cf.resp_ready = ($urandom_range(0, 1) == 1);
                    n++;
                end
            end
        join
        cf.resp_ready = 1'b1;
        wait_drain();

        // Reset with three requests in flight
        cf.resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_rand(ID_W'(i + 8), w);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cf.resp_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("midrst_no_stale", cf.resp_valid, 0);
        send(4'd7, 8'd1, 3'd3, 32'h1, 32'h0, {1'b0, 32'h04200080}, w);
        wait_drain();

        // Wait for the depth-3 instance to finish its traffic
        w = 0;
        while (!done3 && w < 5000) begin
            @(posedge clk);
            w++;
        end
        if (!done3) fail("d3_done_timeout");
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
